// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the MIPS32 instruction fetch front end.
// The optional FETCH_ALIGN_CHECK_EN macro is consumed by the fetch unit files.
package inst_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } if_state_e;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_reg.sv
// PC register with next-PC selection and a single pending-redirect slot.
// Without FETCH_ALIGN_CHECK_EN redirect targets are forced to a word boundary.
module inst_fetch_unit_pc_reg
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              squash,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              pending
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target = redirect_pc;
`else
  assign target = align_word(redirect_pc);
`endif

  // A redirect seen this cycle beats an older pending one; pc+4 wraps naturally.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (redirect)          next_pc = target;
    else if (pend_valid_q) next_pc = pend_pc_q;
    else                   next_pc = pc_q + ADDR_W'(4);
    if (advance || squash) begin
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
    end else if (redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign pc      = pc_q;
  assign pending = pend_valid_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// MIPS32 fetch front end: owns the PC, runs a req/ack fetch and presents one registered word.
// Optional FETCH_ALIGN_CHECK_EN traps a misaligned PC into a sticky error state.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              inst_valid,
  output logic              fetch_misalign,
  output if_state_e         dbg_state
);

  if_state_e         state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] pc;
  logic              pend_valid;
  logic              advance, squash;
  logic              pc_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_misaligned = (pc[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  inst_fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .squash      (squash),
    .redirect    (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pending     (pend_valid)
  );

  // Handshake: imem_req stays high with imem_addr stable until the cycle imem_ack=1;
  // imem_rdata is consumed only in that cycle, ack may arrive in the first req cycle.
  assign imem_req  = !rst && (((state_q == S_REQ) && !pc_misaligned) || (state_q == S_WAIT));
  assign imem_addr = pc;

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;
    advance      = 1'b0;
    squash       = 1'b0;
    case (state_q)
      S_REQ, S_WAIT: begin
        if ((state_q == S_REQ) && pc_misaligned) begin
          state_d    = S_ERR;
          misalign_d = 1'b1;
        end else if (imem_ack) begin
          if (redirect_en || pend_valid) begin
            // Fetch was overtaken by a redirect: drop the data and refetch at the target.
            squash  = 1'b1;
            state_d = S_REQ;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          advance      = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_ERR: begin
        misalign_d   = 1'b1;
        inst_valid_d = 1'b0;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc_plus4       = inst_pc_q + ADDR_W'(4);
  assign inst_valid     = inst_valid_q;
  assign fetch_misalign = misalign_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed fetch/stall/redirect scenarios, then randomized traffic
// checked against a delivered-instruction-stream model.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, stall, redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst, inst_pc, pc_plus4;
  logic        inst_valid, fetch_misalign;
  if_state_e   dbg_state;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4),
    .inst_valid     (inst_valid),
    .fetch_misalign (fetch_misalign),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  logic [31:0] exp_q[$];

  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        rec_req, rec_ack, rec_stall, rec_redir, rec_rst;
  logic [31:0] rec_addr, rec_redir_pc;

  logic [31:0] mdl_next_pc = RESET_PC;
  logic        mdl_redir_v = 1'b0;
  logic [31:0] mdl_redir_pc = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_inst_pc = '0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) * 32'h0001_0003 + 32'h0000_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream model: each delivered word comes from the latest redirect target seen
  // since the previous delivery, otherwise from the previous delivered PC + 4.
  task automatic monitor();
    logic [31:0] exp_pc;
    if (rec_rst) begin
      mdl_next_pc = RESET_PC;
      mdl_redir_v = 1'b0;
      prev_valid  = 1'b0;
    end else begin
      if (rec_redir) begin
        mdl_redir_v = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        mdl_redir_pc = rec_redir_pc;
`else
        mdl_redir_pc = rec_redir_pc & ~32'h3;
`endif
      end
      if (rec_req && !rec_ack) begin
        check("req_held", imem_req, 1'b1);
        check("addr_held", imem_addr, rec_addr);
      end
      if (prev_valid) begin
        check("hold_on_stall", inst_valid, rec_stall);
        if (rec_stall) begin
          check("inst_frozen", inst, prev_inst);
          check("inst_pc_frozen", inst_pc, prev_inst_pc);
          check("no_req_in_hold", imem_req, 1'b0);
        end
      end else if (inst_valid) begin
        exp_pc = mdl_redir_v ? mdl_redir_pc : mdl_next_pc;
        check("deliv_pc", inst_pc, exp_pc);
        check("deliv_inst", inst, rom(exp_pc));
        check("deliv_pc_plus4", pc_plus4, exp_pc + 32'd4);
        mdl_next_pc = exp_pc + 32'd4;
        mdl_redir_v = 1'b0;
        n_deliv++;
      end
`ifndef FETCH_ALIGN_CHECK_EN
      check("misalign_tied0", fetch_misalign, 1'b0);
`endif
      prev_valid   = inst_valid;
      prev_inst    = inst;
      prev_inst_pc = inst_pc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = rom(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        wait_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      wait_cnt   = 0;
    end
    if (rst) wait_cnt = 0;
    rec_req      = imem_req;
    rec_addr     = imem_addr;
    rec_ack      = imem_ack;
    rec_stall    = stall;
    rec_redir    = redirect_en;
    rec_redir_pc = redirect_pc;
    rec_rst      = rst;
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_misalign", fetch_misalign, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(S_REQ));
    rst = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;

    // zero-wait memory: 0,4,8,C with inst_valid on every second cycle
    ack_delay = 0;
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", inst_valid, 32'(i % 2));
      if (i % 2 == 0) begin
        check("t1_req", imem_req, 1'b1);
        check("t1_addr", imem_addr, exp_q.pop_front());
      end else begin
        check("t1_inst", inst, rom(32'((i / 2) * 4)));
      end
      tick();
    end

    // ack three cycles late at 0x4
    do_reset();
    tick();
    ack_delay = 3;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_req", imem_req, 1'b1);
      check("t2_addr", imem_addr, 32'h4);
      check("t2_valid", inst_valid, 1'b0);
      tick();
    end
    check("t2_valid_after", inst_valid, 1'b1);
    check("t2_inst_pc", inst_pc, 32'h4);

    // stall five cycles in hold
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_valid", inst_valid, 1'b1);
      check("t3_inst_pc", inst_pc, 32'h4);
      check("t3_inst", inst, rom(32'h4));
      check("t3_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    tick();
    check("t3_next_addr", imem_addr, 32'h8);
    check("t3_next_req", imem_req, 1'b1);

    // redirect while waiting for memory
    ack_delay = 2;
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    tick();
    check("t4_dropped", inst_valid, 1'b0);
    check("t4_req", imem_req, 1'b1);
    check("t4_addr", imem_addr, 32'h100);
    ack_delay = 0;
    tick();
    check("t4_deliv_pc", inst_pc, 32'h100);

    // two redirects while stalled, latest wins
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_en = 1'b0;
    tick();
    check("t5_frozen_pc", inst_pc, 32'h100);
    stall = 1'b0;
    tick();
    check("t5_req", imem_req, 1'b1);
    check("t5_addr", imem_addr, 32'h300);

    // misaligned redirect target
    redirect_en = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_en = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_no_req", imem_req, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_misalign", fetch_misalign, 1'b1);
      check("t6_err_req", imem_req, 1'b0);
      check("t6_err_valid", inst_valid, 1'b0);
    end
`else
    check("t6_dropped", inst_valid, 1'b0);
    check("t6_addr", imem_addr, 32'h100);
    tick();
    check("t6_deliv_pc", inst_pc, 32'h100);
    check("t6_misalign", fetch_misalign, 1'b0);
`endif

    // pc+4 wraps at the top of the address space
    do_reset();
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_deliv_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    tick();
    check("wrap_addr_zero", imem_addr, 32'h0);

    // randomized traffic against the stream model
    do_reset();
    n_deliv = 0;
    for (int c = 0; c < 3000; c++) begin
      ack_delay   = $urandom_range(0, 3);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 9) == 0);
`ifdef FETCH_ALIGN_CHECK_EN
      redirect_pc = $urandom & ~32'h3;
`else
      redirect_pc = $urandom;
`endif
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst         = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("rand_deliveries", 32'(n_deliv > 100), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
